// File: rtl/bts_onchip_ram_dp_v2.sv
// ---------------------------------------------------------------------------
// bts_onchip_ram_dp_v2
// True-dual-port on-chip scratch RAM with two Avalon-MM slaves (s1, s2) on
// one clock. Reads are fully pipelined with readdatavalid, a clear engine
// fills the array after reset while holding waitrequest, same-address
// accesses resolve deterministically, and write/write collisions are counted.
//
// Ports
//   clk, reset_n            single clock, synchronous active-low reset
//   sN_address              word address (ADDR_WIDTH)
//   sN_chipselect/read/write request qualifiers
//   sN_byteenable           byte lanes (DATA_WIDTH/8)
//   sN_writedata            write data
//   sN_readdata             read data, held while readdatavalid is low
//   sN_readdatavalid        one-cycle pulse READ_LATENCY cycles after accept
//   sN_waitrequest          high during reset and while clearing
//   init_busy               clear engine running
//   collision_count         saturating count of same-address write/write
// ---------------------------------------------------------------------------
module bts_onchip_ram_dp_v2 #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 17,
  parameter int unsigned DEPTH          = 131072,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter logic [31:0] INIT_WORD      = 32'h00000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest,
  output logic                    init_busy,
  output logic [15:0]             collision_count
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] INIT_FILL = DATA_WIDTH'(INIT_WORD);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  state_t                state_r;
  logic [IDX_W-1:0]      cnt_r;
  logic                  wait_r;
  logic                  busy_r;
  logic [15:0]           coll_r;

  // Index 0 is s1, index 1 is s2.
  logic [1:0][ADDR_WIDTH-1:0] addr_s;
  logic [1:0]                 cs_s;
  logic [1:0]                 rd_s;
  logic [1:0]                 wr_s;
  logic [1:0][BE_W-1:0]       be_s;
  logic [1:0][DATA_WIDTH-1:0] wdata_s;
  logic [1:0]                 in_range_s;
  logic [1:0][IDX_W-1:0]      idx_s;
  logic [1:0]                 wr_acc_s;
  logic [1:0]                 rd_acc_s;
  logic [1:0][DATA_WIDTH-1:0] rdword_s;
  logic                       clear_we_s;
  logic                       collide_s;

  logic [1:0]                 p1_valid_r;
  logic [1:0][DATA_WIDTH-1:0] p1_data_r;
  logic [1:0]                 rvalid_r;
  logic [1:0][DATA_WIDTH-1:0] rdata_r;

  // Gather both slaves into arrays and decode acceptance and read data.
  always_comb begin
    addr_s[0]  = s1_address;
    addr_s[1]  = s2_address;
    cs_s       = {s2_chipselect, s1_chipselect};
    rd_s       = {s2_read, s1_read};
    wr_s       = {s2_write, s1_write};
    be_s[0]    = s1_byteenable;
    be_s[1]    = s2_byteenable;
    wdata_s[0] = s1_writedata;
    wdata_s[1] = s2_writedata;
    for (int p = 0; p < 2; p++) begin
      in_range_s[p] = (32'(addr_s[p]) < DEPTH);
      idx_s[p]      = addr_s[p][IDX_W-1:0];
      // read+write together counts as a write only
      wr_acc_s[p]   = reset_n & ~wait_r & cs_s[p] & wr_s[p];
      rd_acc_s[p]   = reset_n & ~wait_r & cs_s[p] & rd_s[p] & ~wr_s[p];
      if (in_range_s[p]) begin
        rdword_s[p] = mem[idx_s[p]];
      end else begin
        rdword_s[p] = '0;
      end
    end
    clear_we_s = reset_n & CLEAR_ON_RESET & (state_r == ST_CLEAR);
    collide_s  = wr_acc_s[0] & wr_acc_s[1] & (addr_s[0] == addr_s[1]);
  end

  // Clear engine FSM with registered waitrequest and init_busy.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_CLEAR;
      cnt_r   <= '0;
      wait_r  <= 1'b1;
      busy_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          if (!CLEAR_ON_RESET || (cnt_r == LAST_IDX)) begin
            state_r <= ST_READY;
            cnt_r   <= '0;
            wait_r  <= 1'b0;
            busy_r  <= 1'b0;
          end else begin
            cnt_r   <= cnt_r + IDX_W'(1);
            wait_r  <= 1'b1;
            busy_r  <= 1'b1;
          end
        end
        ST_READY: begin
          state_r <= ST_READY;
          wait_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_CLEAR;
          cnt_r   <= '0;
          wait_r  <= 1'b1;
          busy_r  <= 1'b1;
        end
      endcase
    end
  end

  // Array writes: clear fill, else s2 then s1 so s1 wins on shared lanes.
  always_ff @(posedge clk) begin
    if (clear_we_s) begin
      mem[cnt_r] <= INIT_FILL;
    end else begin
      if (wr_acc_s[1] && in_range_s[1]) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be_s[1][b]) begin
            mem[idx_s[1]][8*b +: 8] <= wdata_s[1][8*b +: 8];
          end
        end
      end
      if (wr_acc_s[0] && in_range_s[0]) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be_s[0][b]) begin
            mem[idx_s[0]][8*b +: 8] <= wdata_s[0][8*b +: 8];
          end
        end
      end
    end
  end

  // Read pipelines; data is sampled before this edge's writes (read-before-write).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p1_valid_r <= '0;
      p1_data_r  <= '0;
      rvalid_r   <= '0;
      rdata_r    <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        p1_valid_r[p] <= rd_acc_s[p];
        if (rd_acc_s[p]) begin
          p1_data_r[p] <= rdword_s[p];
        end
        if (READ_LATENCY == 2) begin
          rvalid_r[p] <= p1_valid_r[p];
          if (p1_valid_r[p]) begin
            rdata_r[p] <= p1_data_r[p];
          end
        end else begin
          rvalid_r[p] <= rd_acc_s[p];
          if (rd_acc_s[p]) begin
            rdata_r[p] <= rdword_s[p];
          end
        end
      end
    end
  end

  // Saturating same-address write/write collision counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      coll_r <= 16'h0000;
    end else if (collide_s && (coll_r != 16'hFFFF)) begin
      coll_r <= coll_r + 16'd1;
    end
  end

  assign s1_readdata      = rdata_r[0];
  assign s2_readdata      = rdata_r[1];
  assign s1_readdatavalid = rvalid_r[0];
  assign s2_readdatavalid = rvalid_r[1];
  assign s1_waitrequest   = wait_r;
  assign s2_waitrequest   = wait_r;
  assign init_busy        = busy_r;
  assign collision_count  = coll_r;

endmodule

// File: tb/tb_bts_onchip_ram_dp_v2.sv
`timescale 1ns/1ps
module tb_bts_onchip_ram_dp_v2;
  localparam int AW    = 5;
  localparam int DEPTH = 16;
  localparam int LAT   = 2;
  localparam logic [31:0] INIT = 32'hA5A5A5A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic          cs [2];
  logic          rq [2];
  logic          wq [2];
  logic [AW-1:0] a  [2];
  logic [3:0]    be [2];
  logic [31:0]   wd [2];

  logic [AW-1:0] s1_address, s2_address;
  logic s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
  logic [3:0] s1_byteenable, s2_byteenable;
  logic [31:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;
  logic s1_readdatavalid, s2_readdatavalid, s1_waitrequest, s2_waitrequest;
  logic init_busy;
  logic [15:0] collision_count;

  assign s1_address = a[0];  assign s2_address = a[1];
  assign s1_chipselect = cs[0]; assign s2_chipselect = cs[1];
  assign s1_read = rq[0];    assign s2_read = rq[1];
  assign s1_write = wq[0];   assign s2_write = wq[1];
  assign s1_byteenable = be[0]; assign s2_byteenable = be[1];
  assign s1_writedata = wd[0];  assign s2_writedata = wd[1];

  bts_onchip_ram_dp_v2 #(
    .DATA_WIDTH(32), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(LAT),
    .CLEAR_ON_RESET(1'b1), .INIT_WORD(INIT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
    .s1_waitrequest(s1_waitrequest),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid),
    .s2_waitrequest(s2_waitrequest),
    .init_busy(init_busy), .collision_count(collision_count)
  );

  // ---------------- reference model ----------------
  typedef struct { int due; logic [31:0] data; } rd_t;
  rd_t         q0[$];
  rd_t         q1[$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] last_m [2];
  int          coll_m;
  bit          ready_m;
  int          left_m;
  int          cyc;
  int          nchk;
  int          nerr;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] mread(logic [AW-1:0] ad);
    if (int'(ad) < DEPTH) return mem_m[int'(ad)];
    return 32'h0;
  endfunction

  // One clock: update the model from the inputs presented, clock, then compare.
  task automatic step();
    bit wacc [2];
    bit racc [2];
    rd_t e;
    bit have;
    logic [31:0] rdv, vld;
    if (!reset_n) begin
      q0.delete(); q1.delete();
      last_m[0] = 32'h0; last_m[1] = 32'h0;
      coll_m = 0; ready_m = 1'b0; left_m = DEPTH;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = INIT;
    end else begin
      for (int p = 0; p < 2; p++) begin
        wacc[p] = cs[p] && wq[p] && ready_m;
        racc[p] = cs[p] && rq[p] && !wq[p] && ready_m;
      end
      if (racc[0]) q0.push_back('{cyc + LAT, mread(a[0])});
      if (racc[1]) q1.push_back('{cyc + LAT, mread(a[1])});
      if (wacc[0] && wacc[1] && a[0] == a[1])
        coll_m = (coll_m == 65535) ? 65535 : coll_m + 1;
      // s2 applied first; s1 overwrites any lane both enable
      for (int p = 1; p >= 0; p--)
        if (wacc[p] && int'(a[p]) < DEPTH)
          for (int b = 0; b < 4; b++)
            if (be[p][b]) mem_m[int'(a[p])][8*b +: 8] = wd[p][8*b +: 8];
      if (!ready_m) begin
        left_m--;
        if (left_m == 0) ready_m = 1'b1;
      end
    end
    @(posedge clk); #1;
    cyc++;
    for (int p = 0; p < 2; p++) begin
      have = 1'b0;
      if (p == 0) begin
        if (q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); have = 1'b1; end
        rdv = s1_readdata; vld = {31'h0, s1_readdatavalid};
      end else begin
        if (q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); have = 1'b1; end
        rdv = s2_readdata; vld = {31'h0, s2_readdatavalid};
      end
      if (have) last_m[p] = e.data;
      chk($sformatf("rvalid_s%0d", p + 1), vld, {31'h0, have});
      chk($sformatf("rdata_s%0d", p + 1), rdv, last_m[p]);
    end
    chk("wait_s1", {31'h0, s1_waitrequest}, {31'h0, !ready_m});
    chk("wait_s2", {31'h0, s2_waitrequest}, {31'h0, !ready_m});
    chk("init_busy", {31'h0, init_busy}, {31'h0, !ready_m});
    chk("coll_cnt", {16'h0, collision_count}, 32'(coll_m));
  endtask

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      cs[p] = 1'b0; rq[p] = 1'b0; wq[p] = 1'b0;
      a[p] = '0; be[p] = 4'h0; wd[p] = 32'h0;
    end
  endtask

  task automatic set_op(int p, bit r, bit w, logic [AW-1:0] ad, logic [3:0] b, logic [31:0] d);
    cs[p] = 1'b1; rq[p] = r; wq[p] = w; a[p] = ad; be[p] = b; wd[p] = d;
  endtask

  task automatic wr1(logic [AW-1:0] ad, logic [31:0] d, logic [3:0] b);
    idle(); set_op(0, 1'b0, 1'b1, ad, b, d); step(); idle();
  endtask

  task automatic rd1(logic [AW-1:0] ad);
    idle(); set_op(0, 1'b1, 1'b0, ad, 4'hF, 32'h0); step(); idle();
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < LAT + 1; i++) step();
  endtask

  task automatic count_clear(string name);
    int n;
    n = 0;
    while (s1_waitrequest === 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk(name, 32'(n), 32'(DEPTH));
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   pre;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   exp;
  } vec_t;

  vec_t vt [6];
  bit   exp_v [5];

  initial begin
    cyc = 0; nchk = 0; nerr = 0; coll_m = 0; ready_m = 1'b0; left_m = DEPTH;
    last_m[0] = 32'h0; last_m[1] = 32'h0;
    vt[0] = '{5'd4,  32'hFFFFFFFF, 4'b0011, 32'h11223344, 32'hFFFF3344};
    vt[1] = '{5'd6,  32'h00000000, 4'b1000, 32'hDEADBEEF, 32'hDE000000};
    vt[2] = '{5'd7,  32'h12345678, 4'b0000, 32'hFFFFFFFF, 32'h12345678};
    vt[3] = '{5'd8,  32'h00000000, 4'b1111, 32'hCAFEF00D, 32'hCAFEF00D};
    vt[4] = '{5'd15, 32'hFFFFFFFF, 4'b0110, 32'h00000000, 32'hFF0000FF};
    vt[5] = '{5'd18, 32'h11111111, 4'b1111, 32'h22222222, 32'h00000000};
    exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // reset
    reset_n = 1'b0; idle();
    for (int i = 0; i < 3; i++) step();
    chk("rst_rdata", s1_readdata, 32'h0);
    chk("rst_wait", {31'h0, s1_waitrequest}, 32'h1);

    // clear after release lasts DEPTH cycles
    reset_n = 1'b1;
    count_clear("clear_len");
    for (int i = 0; i < DEPTH; i++) rd1(5'(i));
    drain();
    chk("clear_word15", s1_readdata, INIT);

    // back-to-back reads with READ_LATENCY=2
    wr1(5'd0, 32'h100, 4'hF); wr1(5'd1, 32'h101, 4'hF); wr1(5'd2, 32'h102, 4'hF);
    for (int i = 0; i < 5; i++) begin
      idle();
      if (i < 3) set_op(0, 1'b1, 1'b0, 5'(i), 4'hF, 32'h0);
      step();
      chk($sformatf("lat_valid%0d", i), {31'h0, s1_readdatavalid}, {31'h0, exp_v[i]});
      if (exp_v[i]) chk($sformatf("lat_data%0d", i), s1_readdata, 32'h100 + 32'(i - 1));
    end
    drain();

    // byte-lane write table
    for (int i = 0; i < 6; i++) begin
      wr1(vt[i].addr, vt[i].pre, 4'hF);
      wr1(vt[i].addr, vt[i].wdata, vt[i].be);
      rd1(vt[i].addr);
      drain();
      chk($sformatf("vec%0d", i), s1_readdata, vt[i].exp);
    end

    // write/write collision on word 5
    wr1(5'd5, 32'hBBBBBBBB, 4'hF);
    idle();
    set_op(0, 1'b0, 1'b1, 5'd5, 4'b0101, 32'hAAAAAAAA);
    set_op(1, 1'b0, 1'b1, 5'd5, 4'b1100, 32'hBBBBBBBB);
    step();
    rd1(5'd5); drain();
    chk("coll_data", s1_readdata, 32'hBBAABBAA);
    chk("coll_count", {16'h0, collision_count}, 32'd1);

    // read-before-write across ports on word 3
    wr1(5'd3, 32'h0, 4'hF);
    idle();
    set_op(0, 1'b1, 1'b0, 5'd3, 4'hF, 32'h0);
    set_op(1, 1'b0, 1'b1, 5'd3, 4'hF, 32'h12345678);
    step(); drain();
    chk("rbw_old", s1_readdata, 32'h0);
    rd1(5'd3); drain();
    chk("rbw_new", s1_readdata, 32'h12345678);

    // read/read same word
    idle();
    set_op(0, 1'b1, 1'b0, 5'd8, 4'hF, 32'h0);
    set_op(1, 1'b1, 1'b0, 5'd8, 4'hF, 32'h0);
    step(); drain();
    chk("rr_s1", s1_readdata, 32'hCAFEF00D);
    chk("rr_s2", s2_readdata, 32'hCAFEF00D);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      idle();
      for (int p = 0; p < 2; p++)
        set_op(p, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
               5'($urandom_range(19, 0)), 4'($urandom_range(15, 0)), $urandom);
      for (int p = 0; p < 2; p++) cs[p] = 1'($urandom_range(3, 0) != 0);
      step();
    end
    drain();

    // reset pulse in the middle of the clear restarts it from word 0
    reset_n = 1'b0; idle(); step();
    reset_n = 1'b1;
    for (int i = 0; i < 7; i++) step();
    reset_n = 1'b0; step();
    reset_n = 1'b1;
    count_clear("reclear_len");
    for (int i = 0; i < DEPTH; i++) rd1(5'(i));
    drain();
    chk("reclear_word", s1_readdata, INIT);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
